// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture path: duty encoding, FSM states, divider width.
package pwm_capture_pkg;
  localparam int DUTY_STEPS = 10;
  localparam int DIV_BITS   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_e;
endpackage

// File: rtl/pwm_duty_div.sv
// Restoring divider producing a DIV_BITS-bit quotient, one bit per cycle, MSB first.
module pwm_duty_div
  import pwm_capture_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [CW+DIV_BITS-1:0] num_i,
  input  logic [CW-1:0]          den_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [DIV_BITS-1:0]    quot_o
);
  localparam int NW = CW + DIV_BITS;
  localparam int SW = $clog2(DIV_BITS);
  localparam logic [SW-1:0] STEP_MSB = SW'(DIV_BITS - 1);

  logic [NW-1:0]       rem_q, rem_d, dsh;
  logic [CW-1:0]       den_q;
  logic [SW-1:0]       step_q;
  logic [DIV_BITS-1:0] quot_q, quot_d;
  logic                run_q, tail_q, ge;

  // Quotient is known to be < 2**DIV_BITS, so shifted trial subtraction never overflows NW bits.
  assign dsh    = {{DIV_BITS{1'b0}}, den_q} << step_q;
  assign ge     = rem_q >= dsh;
  assign rem_d  = ge ? rem_q - dsh : rem_q;
  assign quot_d = {quot_q[DIV_BITS-2:0], ge};

  // done_o marks the final step; quot_o carries the complete quotient in that cycle.
  assign done_o = run_q && (step_q == '0);
  assign quot_o = quot_d;
  // tail_q keeps the unit busy through the report cycle that follows the last step.
  assign busy_o = run_q | tail_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      tail_q <= 1'b0;
      step_q <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      quot_q <= '0;
    end else if (abort_i) begin
      run_q  <= 1'b0;
      tail_q <= 1'b0;
    end else if (start_i && !busy_o) begin
      run_q  <= 1'b1;
      tail_q <= 1'b0;
      step_q <= STEP_MSB;
      rem_q  <= num_i;
      den_q  <= den_i;
      quot_q <= '0;
    end else if (run_q) begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      if (step_q == '0) begin
        run_q  <= 1'b0;
        tail_q <= 1'b1;
      end else begin
        step_q <= step_q - 1'b1;
      end
    end else begin
      tail_q <= 1'b0;
    end
  end
endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures period/high time of an async input, reports duty in 10% steps,
// flags stuck inputs by timeout and sample drops while the divider is busy.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CW          = 16,
  parameter int TIMEOUT     = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          pwm_in,
  output logic [CW-1:0] period_o,
  output logic [CW-1:0] high_o,
  output logic [3:0]    duty_o,
  output logic          meas_valid_o,
  output logic          stuck_o,
  output logic          overrun_o
);
  localparam int NW = CW + DIV_BITS;
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl, lvl_d1_q, rise, fall, any_edge;
  logic [CW-1:0]          idle_q, idle_d;
  logic                   timeout;

  pwm_state_e    state_q;
  logic [CW-1:0] per_q, hi_q, per_inc, hi_inc;
  logic [CW-1:0] pper_q, phi_q;
  logic          close, div_busy, div_done, div_abort;
  logic [DIV_BITS-1:0] div_quot;
  logic [NW-1:0] num;

  logic [CW-1:0] period_q, high_q;
  logic [3:0]    duty_q;
  logic          valid_q, stuck_q, overrun_q;

  assign lvl      = sync_q[SYNC_STAGES-1];
  assign rise     = lvl & ~lvl_d1_q;
  assign fall     = ~lvl & lvl_d1_q;
  assign any_edge = rise | fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      lvl_d1_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      lvl_d1_q <= lvl;
    end
  end

  // Fires only on the TO_CNT-1 -> TO_CNT step, so a stuck episode reports once.
  assign timeout = ena && !any_edge && (idle_q == TO_CNT - 1'b1);

  always_comb begin
    idle_d = idle_q;
    if (!ena || any_edge)   idle_d = '0;
    else if (idle_q != TO_CNT) idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end

  assign per_inc = (&per_q) ? per_q : per_q + 1'b1;
  assign hi_inc  = (&hi_q)  ? hi_q  : hi_q + 1'b1;

  assign close     = ena && !timeout && (state_q == ST_LOW) && rise;
  assign div_abort = !ena || timeout;
  assign num       = NW'(hi_q) * NW'(DUTY_STEPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      per_q   <= '0;
      hi_q    <= '0;
      pper_q  <= '0;
      phi_q   <= '0;
    end else if (!ena || timeout) begin
      state_q <= ST_IDLE;
      per_q   <= '0;
      hi_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (rise) begin
          state_q <= ST_HIGH;
          per_q   <= '0;
          hi_q    <= '0;
        end
        ST_HIGH: begin
          per_q <= per_inc;
          hi_q  <= hi_inc;
          if (fall) state_q <= ST_LOW;
        end
        ST_LOW: if (rise) begin
          // Closing rise also opens the next period, so consecutive periods have no gap.
          state_q <= ST_HIGH;
          per_q   <= '0;
          hi_q    <= '0;
          if (!div_busy) begin
            pper_q <= per_inc;
            phi_q  <= hi_q;
          end
        end else begin
          per_q <= per_inc;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  pwm_duty_div #(.CW(CW)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (close),
    .abort_i (div_abort),
    .num_i   (num),
    .den_i   (per_inc),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .quot_o  (div_quot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q  <= '0;
      high_q    <= '0;
      duty_q    <= '0;
      valid_q   <= 1'b0;
      stuck_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (close && div_busy) overrun_q <= 1'b1;
      // A timeout in the same cycle as the last divider step discards the division.
      if (timeout) begin
        period_q <= '0;
        high_q   <= '0;
        duty_q   <= lvl ? 4'(DUTY_STEPS) : 4'd0;
        stuck_q  <= 1'b1;
        valid_q  <= 1'b1;
      end else if (div_done && ena) begin
        period_q <= pper_q;
        high_q   <= phi_q;
        duty_q   <= div_quot;
        stuck_q  <= 1'b0;
        valid_q  <= 1'b1;
      end
    end
  end

  assign period_o     = period_q;
  assign high_o       = high_q;
  assign duty_o       = duty_q;
  assign meas_valid_o = valid_q;
  assign stuck_o      = stuck_q;
  assign overrun_o    = overrun_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: synchronous PWM patterns, timeouts, overrun, ena and reset.
module tb_pwm_capture;
  localparam int CW = 16;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst_n, ena, pwm_in;
  logic [CW-1:0] period_o, high_o;
  logic [3:0]    duty_o;
  logic          meas_valid_o, stuck_o, overrun_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int s_t[$], s_per[$], s_hi[$], s_duty[$], s_stuck[$], rise_t[$];

  always #5 clk = ~clk;

  pwm_capture #(.CW(CW), .TIMEOUT(TO), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .pwm_in       (pwm_in),
    .period_o     (period_o),
    .high_o       (high_o),
    .duty_o       (duty_o),
    .meas_valid_o (meas_valid_o),
    .stuck_o      (stuck_o),
    .overrun_o    (overrun_o)
  );

  // Strobe logger, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (meas_valid_o === 1'b1) begin
      s_t.push_back(cyc);
      s_per.push_back(int'(period_o));
      s_hi.push_back(int'(high_o));
      s_duty.push_back(int'(duty_o));
      s_stuck.push_back(int'(stuck_o));
    end
  end

  task automatic clear_log();
    s_t.delete(); s_per.delete(); s_hi.delete();
    s_duty.delete(); s_stuck.delete(); rise_t.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ena = 1'b1; pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives n periods of length p, high for the first h cycles; logs the sample index of each rise drive.
  task automatic run_pwm(input int p, input int h, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++) begin
        @(negedge clk);
        pwm_in = (i < h);
        if (i == 0) rise_t.push_back(cyc + 1);
      end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; pwm_in = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({period_o, high_o, duty_o, meas_valid_o, stuck_o, overrun_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got per=%0d hi=%0d duty=%0d v=%b st=%b ov=%b want all 0",
               period_o, high_o, duty_o, meas_valid_o, stuck_o, overrun_o);
    end
    pwm_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    idle(20);
    checks++;
    if (s_t.size() != 0) begin
      errors++;
      $display("FAIL reset_no_strobe got %0d strobes want 0", s_t.size());
    end
  endtask

  task automatic test_basic();
    do_reset();
    run_pwm(10, 5, 6);
    idle(2);
    checks++;
    if (s_t.size() != 5) begin
      errors++;
      $display("FAIL basic_count got %0d want 5", s_t.size());
    end
    for (int k = 0; k < s_t.size() && k + 1 < rise_t.size(); k++) begin
      checks++;
      if (s_per[k] != 10 || s_hi[k] != 5 || s_duty[k] != 5 || s_stuck[k] != 0) begin
        errors++;
        $display("FAIL basic_report[%0d] got per=%0d hi=%0d duty=%0d stuck=%0d want 10/5/5/0",
                 k, s_per[k], s_hi[k], s_duty[k], s_stuck[k]);
      end
      checks++;
      if (s_t[k] != rise_t[k+1] + 6) begin
        errors++;
        $display("FAIL basic_latency[%0d] got cycle %0d want %0d", k, s_t[k], rise_t[k+1] + 6);
      end
    end
  endtask

  task automatic test_duty_patterns();
    int e_per[5]  = '{10, 10, 10, 10, 20};
    int e_hi[5]   = '{3, 3, 9, 9, 19};
    int e_duty[5] = '{3, 3, 9, 9, 9};
    do_reset();
    run_pwm(10, 3, 2);
    run_pwm(10, 9, 2);
    run_pwm(20, 19, 2);
    idle(2);
    checks++;
    if (s_t.size() != 5) begin
      errors++;
      $display("FAIL duty_count got %0d want 5", s_t.size());
    end
    for (int k = 0; k < s_t.size() && k < 5; k++) begin
      checks++;
      if (s_per[k] != e_per[k] || s_hi[k] != e_hi[k] || s_duty[k] != e_duty[k]) begin
        errors++;
        $display("FAIL duty_report[%0d] got per=%0d hi=%0d duty=%0d want %0d/%0d/%0d",
                 k, s_per[k], s_hi[k], s_duty[k], e_per[k], e_hi[k], e_duty[k]);
      end
    end
  endtask

  task automatic test_stuck_high();
    int n0;
    int nst;
    do_reset();
    run_pwm(10, 5, 2);
    @(negedge clk);
    pwm_in = 1'b1;
    idle(TO + 50);
    nst = 0;
    foreach (s_stuck[k]) nst += s_stuck[k];
    checks++;
    if (s_t.size() != 3 || nst != 1) begin
      errors++;
      $display("FAIL stuck_high_count got %0d strobes %0d stuck want 3 strobes 1 stuck", s_t.size(), nst);
    end
    n0 = s_t.size();
    if (n0 > 0) begin
      checks++;
      if (s_per[n0-1] != 0 || s_hi[n0-1] != 0 || s_duty[n0-1] != 10 || s_stuck[n0-1] != 1) begin
        errors++;
        $display("FAIL stuck_high_report got per=%0d hi=%0d duty=%0d stuck=%0d want 0/0/10/1",
                 s_per[n0-1], s_hi[n0-1], s_duty[n0-1], s_stuck[n0-1]);
      end
    end
    run_pwm(10, 5, 3);
    idle(4);
    checks++;
    if (s_t.size() != n0 + 1) begin
      errors++;
      $display("FAIL stuck_resume_count got %0d want %0d", s_t.size(), n0 + 1);
    end else begin
      checks++;
      if (s_per[n0] != 10 || s_hi[n0] != 5 || s_duty[n0] != 5 || s_stuck[n0] != 0 || stuck_o !== 1'b0) begin
        errors++;
        $display("FAIL stuck_resume_report got per=%0d hi=%0d duty=%0d stuck=%0d out=%b want 10/5/5/0/0",
                 s_per[n0], s_hi[n0], s_duty[n0], s_stuck[n0], stuck_o);
      end
    end
  endtask

  task automatic test_stuck_low();
    do_reset();
    idle(3 * TO);
    checks++;
    if (s_t.size() != 1) begin
      errors++;
      $display("FAIL stuck_low_count got %0d want 1", s_t.size());
    end else begin
      checks++;
      if (s_per[0] != 0 || s_duty[0] != 0 || s_stuck[0] != 1 || overrun_o !== 1'b0) begin
        errors++;
        $display("FAIL stuck_low_report got per=%0d duty=%0d stuck=%0d ov=%b want 0/0/1/0",
                 s_per[0], s_duty[0], s_stuck[0], overrun_o);
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    checks++;
    if (overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL overrun_initial got %b want 0", overrun_o);
    end
    run_pwm(4, 2, 9);
    idle(4);
    checks++;
    if (s_t.size() != 4) begin
      errors++;
      $display("FAIL overrun_count got %0d want 4", s_t.size());
    end
    for (int k = 0; k < s_t.size(); k++) begin
      checks++;
      if (s_per[k] != 4 || s_hi[k] != 2 || s_duty[k] != 5) begin
        errors++;
        $display("FAIL overrun_report[%0d] got per=%0d hi=%0d duty=%0d want 4/2/5",
                 k, s_per[k], s_hi[k], s_duty[k]);
      end
    end
    idle(20);
    checks++;
    if (overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky got %b want 1", overrun_o);
    end
  endtask

  task automatic test_ena();
    do_reset();
    run_pwm(10, 5, 2);
    idle(1);
    @(negedge clk);
    ena = 1'b0;
    run_pwm(10, 3, 3);
    checks++;
    if (s_t.size() != 1 || period_o !== 16'd10 || duty_o !== 4'd5) begin
      errors++;
      $display("FAIL ena_hold got %0d strobes per=%0d duty=%0d want 1 strobe 10/5", s_t.size(), period_o, duty_o);
    end
    @(negedge clk);
    ena = 1'b1;
    run_pwm(10, 3, 3);
    idle(2);
    checks++;
    if (s_t.size() != 3) begin
      errors++;
      $display("FAIL ena_resume_count got %0d want 3", s_t.size());
    end else begin
      checks++;
      if (s_duty[1] != 3 || s_duty[2] != 3 || s_per[2] != 10) begin
        errors++;
        $display("FAIL ena_resume_report got duty=%0d,%0d per=%0d want 3,3 per 10", s_duty[1], s_duty[2], s_per[2]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_pwm(10, 5, 2);
    // Short pulse closes a period, then reset lands in LOW with the division running.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pwm_in = (i < 2);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({period_o, high_o, duty_o, meas_valid_o, stuck_o, overrun_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got per=%0d hi=%0d duty=%0d v=%b st=%b want all 0",
               period_o, high_o, duty_o, meas_valid_o, stuck_o);
    end
    repeat (3) @(negedge clk);
    clear_log();
    rst_n = 1'b1;
    run_pwm(10, 5, 3);
    idle(2);
    checks++;
    if (s_t.size() != 2) begin
      errors++;
      $display("FAIL reset_mid_count got %0d want 2", s_t.size());
    end else begin
      checks++;
      if (s_t[0] != rise_t[1] + 6 || s_per[0] != 10 || s_duty[0] != 5) begin
        errors++;
        $display("FAIL reset_mid_first got cycle %0d per=%0d duty=%0d want cycle %0d 10/5",
                 s_t[0], s_per[0], s_duty[0], rise_t[1] + 6);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; pwm_in = 1'b0;
    test_reset();
    test_basic();
    test_duty_patterns();
    test_stuck_high();
    test_stuck_low();
    test_overrun();
    test_ena();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
